// File: rtl/multi_function_checker.sv
// Stimulus/response checker for the 2-input multifunction logic block.
// Sweeps all 16 {a,b,sel1,sel2} vectors REPEAT times, compares res against
// the golden function and reports error count, first failing vector and pass.
module multi_function_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned REPEAT        = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             res,
  output logic             a,
  output logic             b,
  output logic             sel1,
  output logic             sel2,
  output logic [3:0]       vec_idx,
  output logic             busy,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [3:0]       fail_vec,
  output logic             done,
  output logic             pass
);

  localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned SW_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
  localparam logic [SW_W-1:0] SWEEP_LAST  = SW_W'((REPEAT == 0) ? 0 : REPEAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       vec_q, vec_d;
  logic [SW_W-1:0]  sweep_q, sweep_d;
  logic [SC_W-1:0]  settle_q, settle_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [3:0]       fail_vec_q, fail_vec_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             expected;

  // Golden function of the block under check, selected by {sel1,sel2}
  always_comb begin
    expected = 1'b0;
    unique case (vec_q[1:0])
      2'b00:   expected = vec_q[3] & vec_q[2];
      2'b01:   expected = vec_q[3] | vec_q[2];
      2'b10:   expected = vec_q[3] ^ vec_q[2];
      default: expected = 1'b0;
    endcase
  end

  assign mismatch   = (state_q == S_SAMPLE) && (res != expected);
  assign busy       = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign vec_idx    = vec_q;
  assign a          = vec_q[3];
  assign b          = vec_q[2];
  assign sel1       = vec_q[1];
  assign sel2       = vec_q[0];
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign done       = done_q;
  assign pass       = pass_q;

  // Next-state and datapath updates for the sweep sequencer
  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    sweep_d      = sweep_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = '0;
          pass_d       = 1'b0;
          vec_d        = '0;
          sweep_d      = '0;
          state_d      = S_DRIVE;
        end
      end
      S_DRIVE: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = S_SAMPLE;
        end else begin
          settle_d = settle_q + SC_W'(1);
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + CNT_W'(1);
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        if (vec_q != 4'hF) begin
          vec_d   = vec_q + 4'd1;
          state_d = S_DRIVE;
        end else if (sweep_q != SWEEP_LAST) begin
          vec_d   = '0;
          sweep_d = sweep_q + SW_W'(1);
          state_d = S_DRIVE;
        end else begin
          // pass is judged on the count including this final sample
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      sweep_q      <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      sweep_q      <= sweep_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

endmodule

// File: doc/multi_function_checker.md
Name: multi_function_checker

Overview:
- Self-checking stimulus and response engine for the 2-input multifunction logic block.
- Sits on the opposite side of that block's interface: drives a, b, sel1 and sel2, then samples res and compares it against the golden function.
- Sweeps all 16 input vectors REPEAT times, then reports the error count, the first failing vector and an overall pass flag.
- Replaces hand-written repeat/#delay testers with a clocked, synthesizable checker.

Parameters:
- SETTLE_CYCLES, default 2: idle cycles between driving a vector and sampling res. 0 is legal.
- REPEAT, default 2: number of full 16-vector sweeps per run. Must be 1 or more.
- CNT_W, default 8: width of the error counter.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- start, input, 1: run request, sampled only in IDLE or DONE.
- res, input, 1: result from the block under check.
- a, output, 1: operand, equals vec_idx[3].
- b, output, 1: operand, equals vec_idx[2].
- sel1, output, 1: function select MSB, equals vec_idx[1].
- sel2, output, 1: function select LSB, equals vec_idx[0].
- vec_idx, output, 4: current vector, {a,b,sel1,sel2}.
- busy, output, 1: high while a run is in progress.
- mismatch, output, 1: one-cycle pulse in a SAMPLE cycle when res differs from expected.
- err_count, output, CNT_W: mismatches counted this run, saturating.
- fail_valid, output, 1: set once at least one mismatch has occurred this run.
- fail_vec, output, 4: vec_idx of the first mismatch this run.
- done, output, 1: one-cycle pulse when a run completes.
- pass, output, 1: high in DONE when err_count is 0.

Behaviour:
- Expected function, selected by {sel1,sel2}:
  - 00 gives a AND b.
  - 01 gives a OR b.
  - 10 gives a XOR b.
  - 11 gives 0.
- Reset (asynchronous, rst_n low): every output goes to 0 (including a, b, sel1, sel2, vec_idx, err_count, fail_vec, fail_valid, pass), state goes to IDLE, internal counters clear. A reset mid-run aborts the run with no done pulse.
- States: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: with start=1, clear err_count, fail_valid, fail_vec, pass, vec_idx and the sweep counter, then go to DRIVE.
- DRIVE: one cycle with busy=1. Outputs already reflect vec_idx because they are registered and equal vec_idx.
  - If SETTLE_CYCLES is 0, go to SAMPLE.
  - Otherwise go to SETTLE.
- SETTLE: stay exactly SETTLE_CYCLES cycles, then go to SAMPLE.
- SAMPLE: compare res with expected(vec_idx).
  - On mismatch: pulse mismatch and increment err_count, holding at 2^CNT_W-1.
  - On the first mismatch of the run: latch fail_vec and set fail_valid.
  - Then advance:
    - vec_idx below 15: increment and go to DRIVE.
    - vec_idx is 15 and this is not the last sweep: wrap vec_idx to 0, increment the sweep counter, go to DRIVE.
    - Otherwise: go to DONE.
- DONE:
  - On entry, pulse done for 1 cycle and drop busy.
  - pass = (err_count == 0).
  - err_count, fail_vec, fail_valid and pass hold until the next accepted start.
  - vec_idx holds at 15.
  - start=1 here behaves as in IDLE (clear, then DRIVE).
- start while busy is ignored.
- Timing:
  - Per vector: SETTLE_CYCLES+2 cycles.
  - Full run: 16 × REPEAT × (SETTLE_CYCLES+2) cycles from the first DRIVE to the last SAMPLE.
  - done asserts on the cycle after the last SAMPLE.
- res is used only in SAMPLE. Its value in any other state is don't-care.

Test Plan:
- Ideal DUT connected, SETTLE_CYCLES=2, REPEAT=2, start pulsed → busy stays high for 128 cycles; done pulses once; err_count=0; pass=1; fail_valid=0.
- res tied to 0, defaults → mismatches at vectors 5, 6, 9, 10, 12, 13 in each sweep; err_count=12; fail_vec=5; fail_valid=1; pass=0.
- res tied to 1, defaults → err_count=20; fail_vec=0; with CNT_W=3 instead, err_count saturates at 7.
- SETTLE_CYCLES=0, REPEAT=1, ideal DUT → run completes in 32 cycles; vec_idx steps 0..15, changing every 2 cycles.
- Ideal DUT, start re-asserted at cycle 10 of a run → ignored, and the run length stays 128 cycles. Then rst_n low at cycle 50 → all outputs 0 immediately, state IDLE, no done pulse.
- Ideal DUT with res forced inverted only at vector 10 of sweep 2 → err_count=1; fail_vec=10; a single mismatch pulse seen; then start in DONE → counts clear and a second run passes.
